// File: rtl/wb_write_decoder.sv
// wb_write_decoder
//
// Write-back decoder for the register file. A destination index and write
// request accepted at issue travel down a LAT-deep pipeline of {valid, addr}
// stages. When a write reaches the last (retiring) stage, its one-hot enable is
// presented on Register for exactly one cycle. Every in-flight destination is
// also reflected in Pending so the hazard unit can stall dependent reads.
//
// Parameters:
//   ADDR_W   - register index width
//   NREGS    - number of architectural registers
//   ZERO_REG - hardwired zero register; never written, never pending
//   LAT      - write-back pipeline depth in cycles (1..8)
//
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset; clears all stage valid bits
//   RegWrite - write request from issue
//   WriteReg - destination index for RegWrite
//   Flush    - squashes every non-retiring in-flight write and the concurrent request
//   ReadRegA - read index checked for hazard (HazardA)
//   ReadRegB - read index checked for hazard (HazardB)
//   Register - one-hot write enable from the retiring stage
//   Pending  - per-register "write in flight" scoreboard
//   HazardA  - Pending[ReadRegA]
//   HazardB  - Pending[ReadRegB]
//   InFlight - number of valid stages
//   Busy     - any stage valid
module wb_write_decoder #(
  parameter int ADDR_W   = 5,
  parameter int NREGS    = 2**ADDR_W,
  parameter int ZERO_REG = NREGS-1,
  parameter int LAT      = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteReg,
  input  logic                     Flush,
  input  logic [ADDR_W-1:0]        ReadRegA,
  input  logic [ADDR_W-1:0]        ReadRegB,
  output logic [NREGS-1:0]         Register,
  output logic [NREGS-1:0]         Pending,
  output logic                     HazardA,
  output logic                     HazardB,
  output logic [$clog2(LAT+1)-1:0] InFlight,
  output logic                     Busy
);

  localparam int CNT_W = $clog2(LAT+1);
  localparam int NIDX  = 2**ADDR_W;

  // One extra bit so the range check also works when NREGS == 2**ADDR_W.
  typedef logic [ADDR_W:0] idx_ext_t;
  localparam idx_ext_t NREGS_EXT = idx_ext_t'(NREGS);
  localparam idx_ext_t ZERO_EXT  = idx_ext_t'(ZERO_REG);

  logic [LAT-1:0]    valid_reg;
  logic [LAT-1:0]    valid_next;
  logic [ADDR_W-1:0] addr_reg  [LAT];
  logic [ADDR_W-1:0] addr_next [LAT];
  logic              issue_ok;
  logic [NIDX-1:0]   pending_pad;

  genvar gi;
  genvar gj;

  // Zero-register and out-of-range destinations never become valid, so they
  // can neither pulse Register nor raise Pending.
  assign issue_ok = RegWrite && !Flush &&
                    ({1'b0, WriteReg} < NREGS_EXT) &&
                    ({1'b0, WriteReg} != ZERO_EXT);

  // Next-state for each stage. Flush clears the valid bit of everything that
  // advances; the write that was already retiring has had its pulse this cycle.
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign valid_next[gi] = issue_ok;
        assign addr_next[gi]  = WriteReg;
      end else begin : g_body
        assign valid_next[gi] = valid_reg[gi-1] && !Flush;
        assign addr_next[gi]  = addr_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  // Addresses are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LAT; i++) begin
      addr_reg[i] <= addr_next[i];
    end
  end

  // Per-register decode: Register from the retiring stage only, Pending as
  // the OR of matches across every stage.
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [LAT-1:0] hit;
      for (gj = 0; gj < LAT; gj++) begin : g_hit
        assign hit[gj] = valid_reg[gj] && (addr_reg[gj] == ADDR_W'(gi));
      end
      if (gi == ZERO_REG) begin : g_zero
        assign Register[gi] = 1'b0;
        assign Pending[gi]  = 1'b0;
      end else begin : g_live
        assign Register[gi] = hit[LAT-1];
        assign Pending[gi]  = |hit;
      end
    end
  endgenerate

  // Pad Pending to the full index space so any read index is a legal lookup;
  // indices beyond NREGS are never pending.
  generate
    for (gi = 0; gi < NIDX; gi++) begin : g_pad
      if (gi < NREGS) begin : g_in
        assign pending_pad[gi] = Pending[gi];
      end else begin : g_out
        assign pending_pad[gi] = 1'b0;
      end
    end
  endgenerate

  assign HazardA = pending_pad[ReadRegA];
  assign HazardB = pending_pad[ReadRegB];

  always_comb begin
    InFlight = '0;
    for (int i = 0; i < LAT; i++) begin
      InFlight = InFlight + CNT_W'(valid_reg[i]);
    end
  end

  assign Busy = |valid_reg;

endmodule

// File: tb/tb_wb_write_decoder.sv
module tb_wb_write_decoder;

  localparam int ADDR_W   = 5;
  localparam int NREGS    = 32;
  localparam int ZERO_REG = 31;
  localparam int LAT      = 3;
  localparam int CNT_W    = 2;

  logic              clk      = 1'b0;
  logic              reset_n  = 1'b1;
  logic              RegWrite = 1'b0;
  logic [ADDR_W-1:0] WriteReg = '0;
  logic              Flush    = 1'b0;
  logic [ADDR_W-1:0] ReadRegA = '0;
  logic [ADDR_W-1:0] ReadRegB = '0;
  logic [NREGS-1:0]  Register;
  logic [NREGS-1:0]  Pending;
  logic              HazardA;
  logic              HazardB;
  logic [CNT_W-1:0]  InFlight;
  logic              Busy;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // Expected retirement: destination and the cycle count at which the pulse
  // must be visible (between that edge and the next).
  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } exp_t;
  exp_t exp_q[$];

  wb_write_decoder #(
    .ADDR_W  (ADDR_W),
    .NREGS   (NREGS),
    .ZERO_REG(ZERO_REG),
    .LAT     (LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .RegWrite(RegWrite),
    .WriteReg(WriteReg),
    .Flush   (Flush),
    .ReadRegA(ReadRegA),
    .ReadRegB(ReadRegB),
    .Register(Register),
    .Pending (Pending),
    .HazardA (HazardA),
    .HazardB (HazardB),
    .InFlight(InFlight),
    .Busy    (Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every cycle Register must equal the expected pulse
  // (or zero when nothing is due).
  always @(negedge clk) begin
    logic [NREGS-1:0] exp_reg;
    exp_reg = '0;
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_reg = {{(NREGS-1){1'b0}}, 1'b1} << exp_q[0].addr;
        $display("retire r%0d at cycle %0d", exp_q[0].addr, cyc);
        void'(exp_q.pop_front());
      end
      total++;
      if (Register !== exp_reg) begin
        $display("FAIL register_pulse cycle=%0d got=%h expected=%h", cyc, Register, exp_reg);
      end else begin
        passed++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus, record expected retirements, and return
  // 1 time unit after the sampling edge.
  task automatic drive_cycle(input logic we, input logic [ADDR_W-1:0] wa, input logic fl);
    RegWrite = we;
    WriteReg = wa;
    Flush    = fl;
    if (fl) begin
      while (exp_q.size() > 0 && exp_q[$].due >= cyc + 1) void'(exp_q.pop_back());
    end
    if (we && !fl && wa != ZERO_REG) exp_q.push_back('{addr: wa, due: cyc + LAT});
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    Flush    = 1'b0;
  endtask

  task automatic test_reset();
    RegWrite = 1'b1;
    WriteReg = 5'd4;
    ReadRegA = 5'd4;
    ReadRegB = 5'd4;
    #1 reset_n = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (Pending !== '0) $display("FAIL reset_pending got=%h expected=0", Pending); else passed++;
    total++; if (HazardA !== 1'b0) $display("FAIL reset_hazard_a got=%b expected=0", HazardA); else passed++;
    total++; if (HazardB !== 1'b0) $display("FAIL reset_hazard_b got=%b expected=0", HazardB); else passed++;
    total++; if (InFlight !== '0) $display("FAIL reset_inflight got=%0d expected=0", InFlight); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL reset_busy got=%b expected=0", Busy); else passed++;
    RegWrite = 1'b0;
    reset_n  = 1'b1;
    drive_cycle(1'b1, 5'd4, 1'b0);
    total++; if (Pending !== 32'h10) $display("FAIL reset_first_pending got=%h expected=00000010", Pending); else passed++;
    repeat (LAT + 1) drive_cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_zero_reg();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 5'(ZERO_REG), 1'b0);
      total++; if (Pending !== '0) $display("FAIL zero_pending step=%0d got=%h expected=0", i, Pending); else passed++;
      total++; if (InFlight !== '0) $display("FAIL zero_inflight step=%0d got=%0d expected=0", i, InFlight); else passed++;
    end
    drive_cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    ReadRegA = 5'd7;
    ReadRegB = 5'd8;
    for (int i = 0; i < 5; i++) begin
      logic exp_a;
      exp_a = (i < 4);
      drive_cycle(i < 2, 5'd7, 1'b0);
      total++; if (HazardA !== exp_a) $display("FAIL b2b_hazard_a step=%0d got=%b expected=%b", i, HazardA, exp_a); else passed++;
      total++; if (Pending[7] !== exp_a) $display("FAIL b2b_pending7 step=%0d got=%b expected=%b", i, Pending[7], exp_a); else passed++;
      total++; if (HazardB !== 1'b0) $display("FAIL b2b_hazard_b step=%0d got=%b expected=0", i, HazardB); else passed++;
    end
  endtask

  task automatic test_full_pipeline();
    int exp_if [6] = '{1, 2, 3, 2, 1, 0};
    for (int i = 0; i < 6; i++) begin
      drive_cycle(i < 3, 5'(i + 1), 1'b0);
      total++; if (InFlight !== CNT_W'(exp_if[i])) $display("FAIL full_inflight step=%0d got=%0d expected=%0d", i, InFlight, exp_if[i]); else passed++;
      total++; if (Busy !== (exp_if[i] != 0)) $display("FAIL full_busy step=%0d got=%b expected=%b", i, Busy, exp_if[i] != 0); else passed++;
    end
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 5'd1, 1'b0);
    drive_cycle(1'b1, 5'd2, 1'b0);
    drive_cycle(1'b1, 5'd3, 1'b0);
    total++; if (Pending !== 32'h0000_000e) $display("FAIL flush_pre_pending got=%h expected=0000000e", Pending); else passed++;
    drive_cycle(1'b1, 5'd9, 1'b1);
    total++; if (Pending !== '0) $display("FAIL flush_pending got=%h expected=0", Pending); else passed++;
    total++; if (InFlight !== '0) $display("FAIL flush_inflight got=%0d expected=0", InFlight); else passed++;
    repeat (LAT + 1) drive_cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset_midflight();
    drive_cycle(1'b1, 5'd5, 1'b0);
    total++; if (Pending[5] !== 1'b1) $display("FAIL mid_pending_before got=%b expected=1", Pending[5]); else passed++;
    drive_cycle(1'b0, '0, 1'b0);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    total++; if (Pending !== '0) $display("FAIL mid_pending_after got=%h expected=0", Pending); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL mid_busy got=%b expected=0", Busy); else passed++;
    total++; if (InFlight !== '0) $display("FAIL mid_inflight got=%0d expected=0", InFlight); else passed++;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (LAT + 2) drive_cycle(1'b0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_back_to_back();
    test_full_pipeline();
    test_flush();
    test_reset_midflight();
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_write_decoder.md
# wb_write_decoder

Parametrised write-back decoder for the register file. It takes a destination register index and a write request at issue, carries them through a configurable write-back pipeline, and emits a one-hot write enable when the write retires. It drops writes to the hardwired zero register. It also keeps a per-register pending scoreboard, so the hazard unit can stall reads of registers with writes still in flight. It sits between the decode/issue stage and the register file's write-enable inputs, replacing the fixed 5-to-31 combinational decoder.

## Interface
Parameters:
- ADDR_W, 5: register index width.
- NREGS, 2**ADDR_W: number of architectural registers.
- ZERO_REG, NREGS-1: index of the hardwired zero register. Never written, never pending.
- LAT, 3: write-back pipeline depth in cycles. Legal range 1..8.

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- RegWrite, input, 1: write request from issue, sampled every rising edge.
- WriteReg, input, ADDR_W: destination register index for RegWrite.
- Flush, input, 1: synchronous squash of in-flight, non-retiring writes.
- ReadRegA, input, ADDR_W: read index checked for hazard.
- ReadRegB, input, ADDR_W: read index checked for hazard.
- Register, output, NREGS: one-hot write enable to the register file. Bit ZERO_REG is always 0.
- Pending, output, NREGS: bit r is 1 while any valid stage holds destination r.
- HazardA, output, 1: equals Pending[ReadRegA].
- HazardB, output, 1: equals Pending[ReadRegB].
- InFlight, output, $clog2(LAT+1): count of valid stages.
- Busy, output, 1: InFlight != 0.

## Operation
- Pipeline:
  - LAT stages, each a {valid, addr} register.
  - Stage 0 loads {RegWrite && WriteReg != ZERO_REG && !Flush, WriteReg}.
  - Stage i loads stage i-1.
  - Stage LAT-1 is the retiring stage.
- Register is decoded combinationally from the retiring stage only: bit addr is high iff valid. At most one bit is ever high.
- Zero-register writes never enter the pipeline as valid. They produce no Register pulse and no Pending bit.
- Pending[r] is the OR over all stages, including the retiring stage, of (valid && addr == r). Multiple in-flight writes to the same r keep the bit high until the last one retires.
- HazardA and HazardB are pure combinational lookups of Pending. A request being issued in the current cycle is not yet visible.
- Flush:
  - At the edge where Flush = 1, stages 0..LAT-2 load valid = 0.
  - The concurrent RegWrite is dropped.
  - The write currently in the retiring stage still completes in that cycle, because Register was already high before the edge.
  - For LAT = 1, Flush only drops the concurrent request.
- Out-of-range WriteReg values (index ≥ NREGS, only possible if NREGS < 2**ADDR_W) are treated as zero-register writes and dropped.
- InFlight is the population count of the stage valid bits. Its maximum value is LAT.

## Timing
- Reset (reset_n low, asynchronous): all stage valid bits 0 immediately. Register = 0, Pending = 0, HazardA = HazardB = 0, InFlight = 0, Busy = 0. Stage addr contents are don't-care.
- Reset asserted mid-operation discards all in-flight writes. No Register pulse occurs during or after reset for those writes.
- First sample after reset_n deasserts: the first rising edge with reset_n high.
- Latency: a request sampled at edge k:
  - Register[WriteReg] is high for exactly the one cycle between edges k+LAT-1 and k+LAT.
  - Pending[WriteReg] is high from edge k until edge k+LAT.
- Throughput: one write per cycle. Back-to-back requests produce back-to-back Register pulses in issue order.
- All outputs are functions of stage registers plus ReadRegA/B. There is no combinational path from RegWrite, WriteReg or Flush to any output.

## Test plan
- Reset: hold reset_n = 0 with RegWrite = 1, WriteReg = 4 → all outputs 0. Release, then issue WriteReg = 4 at edge k (LAT = 3) → Register = 32'h10 in the cycle after edge k+2 only.
- Zero register: issue WriteReg = 31 with RegWrite = 1 on 5 consecutive edges → Register = 0, Pending = 0, InFlight = 0 throughout.
- Back-to-back same destination: issue r7 at edges k and k+1 → Register[7] high for 2 consecutive cycles. Pending[7] high from k to k+4. HazardA = 1 with ReadRegA = 7 over that span, HazardB = 0 with ReadRegB = 8.
- Full pipeline: issue r1, r2, r3 on consecutive edges → InFlight goes 1, 2, 3. Busy = 1. Register pulses 0x2, 0x4, 0x8 in order.
- Flush: issue r1, r2, r3, then assert Flush together with RegWrite for r9 → r1 still pulses. r2, r3 and r9 never pulse. Pending = 0 after the following edge.
- Reset mid-flight: issue r5, then pull reset_n low asynchronously between edges → Pending[5] and Busy drop immediately. No Register[5] pulse ever occurs.
